// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// The pipeline sees a byte-addressed 32-bit memory; the board SRAM is 256K x 16.
package arm_mem_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int MEM_BASE    = 1024;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_e;

endpackage

// File: rtl/sram_controller_register.sv
// Generic pipeline register with async active-low clear and a freeze (hold) input.
module Register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (!freeze_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two 16-bit SRAM half-accesses (low then high),
// holding the pipeline frozen through ready until the access completes.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int BIT_NUMBER  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [BIT_NUMBER-1:0]  address,
  input  logic [BIT_NUMBER-1:0]  wr_data,
  output logic [BIT_NUMBER-1:0]  rd_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic                   SRAM_WE_N
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]             rstSync_q;
  logic                   rstInt_n;
  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [16:0]            word_q, word_d;
  logic [31:0]            wrData_q, wrData_d;
  logic                   isWrite_q, isWrite_d;
  logic                   sampleLo, sampleHi;
  logic [BIT_NUMBER-1:0]  offset;
  logic                   unusedOffsetBits;
  logic                   dqDrive;
  logic [SRAM_DATA_W-1:0] dqOut;
  logic [SRAM_DATA_W-1:0] rdLo, rdHi;

  // Assertion is immediate; release is retimed to clk so no flop sees a mid-cycle deassert.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstSync_q <= '0;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstInt_n = rstSync_q[1];

  // Word index relative to the data segment base; bits above 16 are dropped so it wraps at 512 KiB.
  assign offset           = address - BIT_NUMBER'(MEM_BASE);
  assign unusedOffsetBits = ^{offset[BIT_NUMBER-1:19], offset[1:0]};

  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      wrData_q  <= '0;
      isWrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      wrData_q  <= wrData_d;
      isWrite_q <= isWrite_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    wrData_d  = wrData_q;
    isWrite_d = isWrite_q;
    sampleLo  = 1'b0;
    sampleHi  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          state_d   = LO;
          cnt_d     = CNT_LOAD;
          word_d    = offset[18:2];
          wrData_d  = wr_data[31:0];
          isWrite_d = wr_en;
        end
      end
      LO: begin
        if (cnt_q == 4'd0) begin
          state_d  = HI;
          cnt_d    = CNT_LOAD;
          sampleLo = !isWrite_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HI: begin
        if (cnt_q == 4'd0) begin
          state_d  = DONE;
          cnt_d    = 4'd0;
          sampleHi = !isWrite_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The bus is only ever driven while a write phase is active.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dqDrive   = 1'b0;
    dqOut     = wrData_q[15:0];
    if (state_q == LO || state_q == HI) begin
      SRAM_ADDR = {word_q, (state_q == HI)};
      SRAM_WE_N = !isWrite_q;
      dqDrive   = isWrite_q;
      if (state_q == HI) begin
        dqOut = wrData_q[31:16];
      end
    end
  end

  assign SRAM_DQ = dqDrive ? dqOut : {SRAM_DATA_W{1'bz}};

  assign ready = !rst || (state_q == IDLE && !(wr_en || rd_en)) || (state_q == DONE);

  Register #(.WIDTH(SRAM_DATA_W)) rdLoReg (
    .clk      (clk),
    .rst_n    (rstInt_n),
    .freeze_i (!sampleLo),
    .d_i      (SRAM_DQ),
    .q_o      (rdLo)
  );

  Register #(.WIDTH(SRAM_DATA_W)) rdHiReg (
    .clk      (clk),
    .rst_n    (rstInt_n),
    .freeze_i (!sampleHi),
    .d_i      (SRAM_DQ),
    .q_o      (rdHi)
  );

  assign rd_data = BIT_NUMBER'({rdHi, rdLo});

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM array model on the bus, word-level reference memory,
// directed cases followed by randomized load/store traffic.
module tb_sram_controller;

  localparam int W  = 2;
  localparam int W1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn, rdEn;
  logic [31:0] addrIn, wrDataIn, rdDataOut;
  logic        ready;
  logic [17:0] sramAddr;
  wire  [15:0] sramDq;
  logic        sramWeN;

  logic        wrEn1, rdEn1;
  logic [31:0] addrIn1, wrDataIn1, rdDataOut1;
  logic        ready1;
  logic [17:0] sramAddr1;
  wire  [15:0] sramDq1;
  logic        sramWeN1;

  logic [15:0] sramMem [0:262143];
  logic [31:0] refMem [int];
  logic [31:0] expRd;
  int          checks = 0;
  int          errors = 0;
  int          accessNum = 0;

  always #5 clk = ~clk;

  sram_controller #(.BIT_NUMBER(32), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wrEn),
    .rd_en     (rdEn),
    .address   (addrIn),
    .wr_data   (wrDataIn),
    .rd_data   (rdDataOut),
    .ready     (ready),
    .SRAM_ADDR (sramAddr),
    .SRAM_DQ   (sramDq),
    .SRAM_WE_N (sramWeN)
  );

  sram_controller #(.BIT_NUMBER(32), .WAIT_CYCLES(W1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wrEn1),
    .rd_en     (rdEn1),
    .address   (addrIn1),
    .wr_data   (wrDataIn1),
    .rd_data   (rdDataOut1),
    .ready     (ready1),
    .SRAM_ADDR (sramAddr1),
    .SRAM_DQ   (sramDq1),
    .SRAM_WE_N (sramWeN1)
  );

  // Asynchronous SRAM: drives the bus whenever not being written, captures on WE_N low.
  assign sramDq = sramWeN ? sramMem[sramAddr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sramWeN) sramMem[sramAddr] <= sramDq;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refGet(input int w);
    if (refMem.exists(w)) return refMem[w];
    return 32'h0;
  endfunction

  // One complete access on the W=2 instance, checked cycle by cycle from the request cycle.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                               input logic [31:0] data, input bit scramble);
    int          word;
    int          half;
    bit          isWrite;
    logic [31:0] offset;
    string       t;
    offset  = addr - 32'd1024;
    word    = int'((offset / 32'd4) % 32'd131072);
    isWrite = wr;
    if (!isWrite) expRd = refGet(word);
    accessNum++;
    @(negedge clk);
    wrEn = wr; rdEn = rd; addrIn = addr; wrDataIn = data;
    for (int k = 0; k <= 2 * W + 1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (scramble && k <= 2 * W) begin
          addrIn   = $urandom;
          wrDataIn = $urandom;
        end
      end
      #1;
      t = $sformatf("acc%0d_c%0d", accessNum, k);
      checkOutput({t, "_ready"}, 32'(ready), 32'(k == 2 * W + 1));
      if (k >= 1 && k <= 2 * W) begin
        half = (k > W) ? 1 : 0;
        checkOutput({t, "_addr"}, 32'(sramAddr), 32'(word * 2 + half));
        checkOutput({t, "_wen"}, 32'(sramWeN), 32'(!isWrite));
        if (isWrite) checkOutput({t, "_dq"}, 32'(sramDq), (half == 1) ? 32'(data[31:16]) : 32'(data[15:0]));
      end else begin
        checkOutput({t, "_wen"}, 32'(sramWeN), 32'd1);
      end
      if (k == 2 * W + 1) checkOutput({t, "_rdata"}, rdDataOut, expRd);
    end
    if (isWrite) refMem[word] = data;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wrEn = 1'b0; rdEn = 1'b0;
      #1;
      checkOutput("idle_ready", 32'(ready), 32'd1);
      checkOutput("idle_wen", 32'(sramWeN), 32'd1);
      checkOutput("idle_rdata", rdDataOut, expRd);
    end
  endtask

  task automatic resetDuringWrite();
    @(negedge clk);
    wrEn = 1'b1; rdEn = 1'b0; addrIn = 32'd1024 + 32'd4000; wrDataIn = 32'hCAFEF00D;
    repeat (W + 1) @(negedge clk);
    #1;
    checkOutput("rstw_hi_addr", 32'(sramAddr), 32'd2001);
    checkOutput("rstw_hi_wen", 32'(sramWeN), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstw_wen", 32'(sramWeN), 32'd1);
    checkOutput("rstw_ready", 32'(ready), 32'd1);
    checkOutput("rstw_addr", 32'(sramAddr), 32'd0);
    checkOutput("rstw_rdata", rdDataOut, 32'd0);
    wrEn = 1'b0;
    expRd = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2 * W + 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rstw_after%0d_wen", i), 32'(sramWeN), 32'd1);
      checkOutput($sformatf("rstw_after%0d_ready", i), 32'(ready), 32'd1);
      checkOutput($sformatf("rstw_after%0d_addr", i), 32'(sramAddr), 32'd0);
    end
  endtask

  // W=1 instance: a store just below the base wraps to the top of the SRAM.
  task automatic wrapBelowBase();
    int lowCount;
    lowCount = 0;
    @(negedge clk);
    wrEn1 = 1'b1; rdEn1 = 1'b0; addrIn1 = 32'd1020; wrDataIn1 = 32'h13579BDF;
    for (int k = 0; k <= 2 * W1 + 1; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (!ready1) lowCount++;
      checkOutput($sformatf("wrap_c%0d_ready", k), 32'(ready1), 32'(k == 2 * W1 + 1));
      if (k == 1) begin
        checkOutput("wrap_lo_addr", 32'(sramAddr1), 32'h3FFFE);
        checkOutput("wrap_lo_wen", 32'(sramWeN1), 32'd0);
        checkOutput("wrap_lo_dq", 32'(sramDq1), 32'h9BDF);
      end
      if (k == 2) begin
        checkOutput("wrap_hi_addr", 32'(sramAddr1), 32'h3FFFF);
        checkOutput("wrap_hi_wen", 32'(sramWeN1), 32'd0);
        checkOutput("wrap_hi_dq", 32'(sramDq1), 32'h1357);
      end
    end
    checkOutput("wrap_ready_low_cycles", 32'(lowCount), 32'd3);
    checkOutput("wrap_rdata_untouched", rdDataOut1, 32'd0);
    @(negedge clk);
    wrEn1 = 1'b0;
  endtask

  initial begin
    logic [31:0] randWord;
    rst = 1'b1;
    wrEn = 1'b1; rdEn = 1'b0; addrIn = 32'd1024; wrDataIn = 32'h0;
    wrEn1 = 1'b0; rdEn1 = 1'b0; addrIn1 = 32'd0; wrDataIn1 = 32'h0;
    expRd = 32'h0;
    for (int i = 0; i < 262144; i++) sramMem[i] <= 16'h0;
    sramMem[4] <= 16'h1234;
    sramMem[5] <= 16'hABCD;
    refMem[2] = 32'hABCD1234;

    #2 rst = 1'b0;
    #1;
    checkOutput("reset_ready_with_request", 32'(ready), 32'd1);
    checkOutput("reset_wen", 32'(sramWeN), 32'd1);
    checkOutput("reset_addr", 32'(sramAddr), 32'd0);
    checkOutput("reset_rdata", rdDataOut, 32'd0);
    checkOutput("reset_ready1", 32'(ready1), 32'd1);
    @(negedge clk);
    wrEn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idleCycles(3);

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b1, 32'd1028, 32'h00000055, 1'b0);
    idleCycles(1);
    randWord = $urandom;
    applyStimulus(1'b1, 1'b0, 32'd2000, randWord, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd2000, 32'h0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
    idleCycles(1);

    $display("[TB] reset during write");
    resetDuringWrite();

    $display("[TB] wrap below base on W=1 instance");
    wrapBelowBase();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'd1016 + 32'($urandom_range(0, 7));
      else a = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      applyStimulus(op != 1, op != 0, a, $urandom, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 2)));
    end
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter BIT_NUMBER, default 32: width of the pipeline-side address and data.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 1..15: clock cycles spent on each 16-bit SRAM half-access.
REQ-003 clk  input  1: the single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset; asynchronous, active-low.
REQ-005 wr_en  input  1: MEM-stage store request; held stable until ready is high.
REQ-006 rd_en  input  1: MEM-stage load request; held stable until ready is high.
REQ-007 address  input  BIT_NUMBER: byte address from the ALU result.
REQ-008 wr_data  input  BIT_NUMBER: store data.
REQ-009 rd_data  output  BIT_NUMBER: load result; feeds the Mem_read_value_in input of the MEM/WB register.
REQ-010 ready  output  1: request complete, or no request pending; when low, the pipeline freezes.
REQ-011 SRAM_ADDR  output  18: SRAM half-word address.
REQ-012 SRAM_DQ  inout  16: SRAM data bus.
REQ-013 SRAM_WE_N  output  1: SRAM write strobe, active-low.

Function
REQ-014 The block SHALL implement states IDLE, LO, HI and DONE.
REQ-015 In IDLE with wr_en or rd_en high, the block SHALL latch the address, the data and the operation, and go to LO on the next edge.
REQ-016 When wr_en and rd_en are both high, the block SHALL perform a write.
REQ-017 The block SHALL stay exactly WAIT_CYCLES cycles in LO, then exactly WAIT_CYCLES cycles in HI, then one cycle in DONE, then return to IDLE unconditionally.
REQ-018 The phase counter SHALL be 4 bits wide, reload at every phase entry, and never wrap within a phase.
REQ-019 ready SHALL be high when (IDLE and no request) or DONE, and low otherwise.
REQ-020 ready SHALL be combinational from state and the request inputs, so it drops low in the same cycle a request appears.
REQ-021 Latency for WAIT_CYCLES=W: ready SHALL be low for 2W+1 cycles, and ready SHALL be high in cycle 2W+1 counted from the request cycle 0.
REQ-022 Address mapping: word = (address - 1024) mod 2^32 >> 2; SRAM_ADDR = {word[16:0], half}; half = 0 in LO and 1 in HI.
REQ-023 Upper word bits beyond bit 16 SHALL be discarded, so the address wraps modulo 512 KiB.
REQ-024 Write, LO phase: SRAM_DQ SHALL be driven with wr_data[15:0] and SRAM_WE_N held low for all LO cycles.
REQ-025 Write, HI phase: SRAM_DQ SHALL be driven with wr_data[31:16] and SRAM_WE_N held low for all HI cycles.
REQ-026 Write: SRAM_WE_N SHALL be high in IDLE and DONE.
REQ-027 Read: SRAM_DQ SHALL be high-impedance and SRAM_WE_N high throughout.
REQ-028 Read: SRAM_DQ SHALL be sampled on the last cycle of LO into rd_data[15:0] and on the last cycle of HI into rd_data[31:16].
REQ-029 rd_data SHALL be valid in DONE and SHALL hold until the next read overwrites it; writes SHALL leave rd_data unchanged.
REQ-030 Requests arriving in DONE SHALL be ignored, because the pipeline advances on that edge.
REQ-031 A request present in the IDLE cycle after DONE SHALL start a new access, allowing back-to-back accesses.
REQ-032 Request inputs SHALL be ignored in LO and HI; the latched copies govern the access.
REQ-033 When SRAM_DQ is not driven, it SHALL be high-impedance; outside write phases the bus SHALL never be driven.

Reset
REQ-034 Asserting rst at any time, including mid-access, SHALL immediately force IDLE, counter 0, rd_data 0, SRAM_ADDR 0, SRAM_WE_N 1 and SRAM_DQ high-impedance.
REQ-035 While rst is low, ready SHALL be high.
REQ-036 An access interrupted by reset SHALL be abandoned and not resumed.
REQ-037 Reset deassertion SHALL be synchronised to clk; the first active edge is the cycle after release.

Structure
REQ-038 Package arm_mem_pkg SHALL hold the state enum, SRAM_ADDR_W=18, SRAM_DATA_W=16 and MEM_BASE=1024.
REQ-039 The rd_data halves SHALL use the existing Register block with freeze tied to the sample enable negated.
REQ-040 No other sub-module SHALL be used.

Verification
REQ-041 W=2; write 0xDEADBEEF to address 1024 -> SRAM_ADDR 0 with DQ 0xBEEF for 2 cycles, then SRAM_ADDR 1 with DQ 0xDEAD for 2 cycles, WE_N low for 4 cycles, and ready high in cycle 5.
REQ-042 Read address 1032 with the SRAM model returning 0x1234 at half-address 4 and 0xABCD at half-address 5 -> rd_data 0xABCD1234 in DONE, held afterwards.
REQ-043 wr_en=rd_en=1 at address 1028 with data 0x00000055 -> write to half-addresses 2 and 3, and rd_data unchanged.
REQ-044 Back-to-back write then read of the same address 2000 -> read returns the written value, and the second access starts in the cycle after DONE.
REQ-045 Reset pulsed during HI of a write -> WE_N high and DQ high-impedance immediately, state IDLE, ready high, and no third SRAM cycle.
REQ-046 Address 1020 (below base) with W=1 -> SRAM_ADDR wraps to 0x3FFFE/0x3FFFF, and ready is low for 3 cycles.
